sd_sector_tx_buffer: RTL and testbench
======================================

Name: sd_sector_tx_buffer

Overview:
Parametrised SD write-sector buffer. The CPU side fills one data block by random-access word writes. On commit, the block is streamed out as bytes over a valid/ready handshake to the SD SPI transmitter, optionally followed by the SD data CRC16. Sits between the CPU/MMIO write path and the SD SPI byte engine, and is the successor to the fixed 256x16 sector write buffer.

Parameters:
DATA_W, 16, write word width in bits; must be a multiple of 8.
DEPTH_WORDS, 256, words per block (DATA_W*DEPTH_WORDS/8 = block bytes; 512 at defaults).
CRC_EN, 1, 1 = append 2-byte CRC16-CCITT after the data bytes; 0 = data bytes only.
ADDR_W, $clog2(DEPTH_WORDS), derived localparam; not overridable.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  synchronous, active-high.
wr_en  in  1  word write strobe.
wr_addr  in  ADDR_W  word address.
wr_data  in  DATA_W  word data.
clear  in  1  zero all buffer words (FILL state only).
commit  in  1  start streaming the block (FILL state only).
busy  out  1  high in SEND_DATA/SEND_CRC.
out_data  out  8  byte to SPI engine.
out_valid  out  1  out_data valid.
out_ready  in  1  SPI engine accepts a byte when out_valid && out_ready.
done  out  1  one-cycle pulse after the final byte is accepted.

Behaviour:
- Reset (synchronous, active-high): state FILL; all words 0; busy=0, out_valid=0, out_data=0, done=0; byte counter=0; CRC register=0.
- Storage: DEPTH_WORDS x DATA_W register array.
- States: FILL -> SEND_DATA -> SEND_CRC (only when CRC_EN=1) -> FILL.
- FILL:
  - wr_en writes mem[wr_addr] <= wr_data on that edge.
  - clear zeroes every word on that edge.
  - clear and wr_en in the same cycle: clear wins for all words except wr_addr, which takes wr_data.
  - commit moves to SEND_DATA on the next edge. A write in the commit cycle lands and is included in the block.
- Byte order: word 0 first, then ascending addresses. Within a word, most-significant byte first (wr_data[DATA_W-1 -: 8] first). Within a byte, bit 7 is the MSB; SD/SPI shifts MSB first.
- SEND_DATA:
  - out_valid rises the cycle after commit is sampled (latency 1), carrying byte 0.
  - On each out_valid && out_ready edge: byte counter increments and the next byte is presented on the next cycle with no bubble, so full throughput is 1 byte/clk.
  - While out_valid && !out_ready, out_data and out_valid hold stable.
  - After the last data byte is accepted: go to SEND_CRC if CRC_EN=1, else FILL.
- CRC:
  - CRC16-CCITT, polynomial 0x1021, init 0x0000, no reflection, no final XOR.
  - Updated with each data byte on its accept edge.
  - SEND_CRC presents crc[15:8], then crc[7:0], under the same handshake. The CRC value is frozen during SEND_CRC.
- Completion:
  - After the final byte (CRC low, or last data byte when CRC_EN=0) is accepted: next cycle out_valid=0, busy=0, done=1 for exactly one cycle, state FILL.
  - CRC register and counter return to 0. Buffer contents are retained, so a re-commit resends the same block.
- While busy: wr_en, clear and commit are ignored; no contents change.
- reset mid-send: at the next edge everything returns to reset values, including zeroed contents; no done pulse.
- Counter width: $clog2(block bytes + 2). It never wraps; the terminal byte count is compared exactly.

Decomposition:
- Package sd_pkg: SD_CRC16_POLY=16'h1021, state enum (FILL, SEND_DATA, SEND_CRC), SD_BLOCK_BYTES=512.
- Sub-module sd_crc16_byte: combinational next_crc = f(crc, byte), reusable by the SD read path for CRC checking.

Test Plan:
- Reset, no writes, commit, out_ready=1 -> 512 bytes 0x00, then 0x00, 0x00; 514 beats on consecutive cycles; done pulses 1 cycle after the last beat.
- Write all 256 words 0xFFFF, commit, out_ready=1 -> 512 x 0xFF, then 0x7F, 0xA1; busy low and done high on the cycle after the last beat.
- Write addr 0 = 0x1234, addr 255 = 0xABCD, clear not used, commit -> beat0=0x12, beat1=0x34, beats 510/511 = 0xAB, 0xCD. Then write addr 0 = 0x5678 in the commit cycle of a second send -> beat0=0x56, beat1=0x78.
- Pseudo-random out_ready (~50% duty) over the 0xFFFF block -> out_data stable while stalled; exactly 514 accepted bytes; same sequence and CRC 0x7FA1.
- During SEND_DATA, assert wr_en (addr 3, 0xDEAD), clear and commit -> all ignored; stream unchanged; after done, re-commit streams the original block.
- Assert reset at beat 100 -> next cycle out_valid=0, busy=0, no done; contents read back as zero on the next commit. Repeat with CRC_EN=0 -> exactly 512 beats, no CRC bytes.

Source files
------------

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared SD constants and sector buffer state encodings
package sd_pkg;

  localparam logic [15:0] SD_CRC16_POLY  = 16'h1021;
  localparam int          SD_BLOCK_BYTES = 512;

  localparam logic [1:0] FILL      = 2'd0;
  localparam logic [1:0] SEND_DATA = 2'd1;
  localparam logic [1:0] SEND_CRC  = 2'd2;

endpackage

// File: rtl/sd_crc16_byte.sv
// rtl/sd_crc16_byte.sv - combinational CRC16-CCITT update by one byte, MSB first
module sd_crc16_byte
  import sd_pkg::*;
(
  input  logic [15:0] crc,
  input  logic [7:0]  data,
  output logic [15:0] next_crc
);

  always_comb begin
    next_crc = crc;
    for (int i = 7; i >= 0; i--) begin
      if (next_crc[15] ^ data[i]) begin
        next_crc = {next_crc[14:0], 1'b0} ^ SD_CRC16_POLY;
      end else begin
        next_crc = {next_crc[14:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/sd_sector_tx_buffer.sv
// rtl/sd_sector_tx_buffer.sv - CPU-filled SD write block streamed as bytes with optional CRC16
module sd_sector_tx_buffer
  import sd_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int DEPTH_WORDS = 256,
  parameter int CRC_EN      = 1,
  localparam int ADDR_W     = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear,
  input  logic              commit,
  output logic              busy,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done
);

  localparam int BPW         = DATA_W / 8;
  localparam int BLOCK_BYTES = BPW * DEPTH_WORDS;
  localparam int CNT_W       = $clog2(BLOCK_BYTES + 2);
  localparam int BSEL_W      = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [CNT_W-1:0]  LAST_DATA = CNT_W'(BLOCK_BYTES - 1);
  localparam logic [CNT_W-1:0]  CRC_HI    = CNT_W'(BLOCK_BYTES);
  localparam logic [CNT_W-1:0]  LAST_CRC  = CNT_W'(BLOCK_BYTES + 1);
  localparam logic [BSEL_W-1:0] LAST_BSEL = BSEL_W'(BPW - 1);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] word_ptr;
  logic [BSEL_W-1:0] byte_sel;
  logic [15:0]       crc;
  logic [15:0]       crc_next;
  logic [DATA_W-1:0] word_shifted;
  logic [7:0]        data_byte;
  logic              accept;
  logic              last_beat;

  assign busy      = (state != FILL);
  assign out_valid = busy;
  assign accept    = out_valid && out_ready;

  // Most-significant byte of each word goes out first.
  assign word_shifted = mem[word_ptr] >> {LAST_BSEL - byte_sel, 3'b000};
  assign data_byte    = word_shifted[7:0];

  assign last_beat = ((state == SEND_DATA) && (cnt == LAST_DATA) && (CRC_EN == 0)) ||
                     ((state == SEND_CRC) && (cnt == LAST_CRC));

  always_comb begin
    out_data = 8'h00;
    case (state)
      SEND_DATA: out_data = data_byte;
      SEND_CRC:  out_data = (cnt == CRC_HI) ? crc[15:8] : crc[7:0];
      default:   out_data = 8'h00;
    endcase
  end

  sd_crc16_byte u_crc (
    .crc      (crc),
    .data     (data_byte),
    .next_crc (crc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (state == FILL) begin
      if (clear) begin
        for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
      end
      // Later assignment lets the written word survive a simultaneous clear.
      if (wr_en) mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FILL;
      cnt      <= '0;
      word_ptr <= '0;
      byte_sel <= '0;
      crc      <= 16'h0000;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        FILL: begin
          if (commit) state <= SEND_DATA;
        end
        SEND_DATA: begin
          if (accept) begin
            crc <= crc_next;
            if (byte_sel == LAST_BSEL) begin
              byte_sel <= '0;
              word_ptr <= word_ptr + ADDR_W'(1);
            end else begin
              byte_sel <= byte_sel + BSEL_W'(1);
            end
            if (cnt == LAST_DATA) begin
              word_ptr <= '0;
              if (CRC_EN != 0) begin
                state <= SEND_CRC;
                cnt   <= cnt + CNT_W'(1);
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        SEND_CRC: begin
          if (accept && !last_beat) cnt <= cnt + CNT_W'(1);
        end
        default: state <= FILL;
      endcase
      if (accept && last_beat) begin
        state    <= FILL;
        cnt      <= '0;
        word_ptr <= '0;
        byte_sel <= '0;
        crc      <= 16'h0000;
        done     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sd_sector_tx_buffer.sv
// tb/tb_sd_sector_tx_buffer.sv - directed bench for sd_sector_tx_buffer with and without CRC
module tb_sd_sector_tx_buffer;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        clear;
  logic        commit;
  logic        out_ready;

  logic        a_busy, a_valid, a_done;
  logic [7:0]  a_data;
  logic        b_busy, b_valid, b_done;
  logic [7:0]  b_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] tb_mem [256];
  logic [7:0]  exp_q [$];
  logic [15:0] exp_crc;
  logic [7:0]  qa [$];
  logic [7:0]  qb [$];
  int a_first, a_last, b_last;
  int a_done_cyc, b_done_cyc, a_done_n, b_done_n;
  int stall_err, done_flag_err;

  sd_sector_tx_buffer u_crc (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear(clear), .commit(commit), .busy(a_busy), .out_data(a_data),
    .out_valid(a_valid), .out_ready(out_ready), .done(a_done)
  );

  sd_sector_tx_buffer #(.CRC_EN(0)) u_nocrc (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear(clear), .commit(commit), .busy(b_busy), .out_data(b_data),
    .out_valid(b_valid), .out_ready(out_ready), .done(b_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  task automatic build_exp();
    exp_q.delete();
    exp_crc = 16'h0000;
    for (int w = 0; w < 256; w++) begin
      exp_q.push_back(tb_mem[w][15:8]);
      exp_q.push_back(tb_mem[w][7:0]);
    end
    for (int i = 0; i < 512; i++) exp_crc = crc_ref(exp_crc, exp_q[i]);
  endtask

  task automatic wr_word(input logic [7:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    tb_mem[a] = d;
  endtask

  task automatic do_commit(input bit w, input logic [7:0] a, input logic [15:0] d);
    commit = 1'b1;
    if (w) begin wr_en = 1'b1; wr_addr = a; wr_data = d; end
    @(negedge clk);
    commit = 1'b0; wr_en = 1'b0;
    if (w) tb_mem[a] = d;
    build_exp();
    check("valid_latency", {29'd0, a_valid, b_valid, a_busy}, 32'h7);
    check("beat0_present", a_data, exp_q[0]);
  endtask

  task automatic run_stream(input int mode, input int disturb_at, input int reset_at);
    int cyc;
    bit stop;
    bit prev_stall_a, prev_stall_b;
    logic [7:0] prev_a, prev_b;
    qa.delete(); qb.delete();
    a_first = -1; a_last = -1; b_last = -1;
    a_done_cyc = -1; b_done_cyc = -1; a_done_n = 0; b_done_n = 0;
    stall_err = 0; done_flag_err = 0;
    prev_stall_a = 0; prev_stall_b = 0; prev_a = 0; prev_b = 0;
    cyc = 0; stop = 0;
    while (!stop && cyc < 4000 && !(a_done_cyc >= 0 && b_done_cyc >= 0)) begin
      out_ready = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      wr_en = 1'b0; clear = 1'b0; commit = 1'b0;
      if (cyc == disturb_at) begin
        wr_en = 1'b1; wr_addr = 8'd3; wr_data = 16'hDEAD; clear = 1'b1; commit = 1'b1;
      end
      if (reset_at >= 0 && qa.size() == reset_at) begin
        reset = 1'b1; out_ready = 1'b0; stop = 1;
      end
      if (prev_stall_a && (a_valid !== 1'b1 || a_data !== prev_a)) stall_err++;
      if (prev_stall_b && (b_valid !== 1'b1 || b_data !== prev_b)) stall_err++;
      if (a_done) begin
        if (a_done_cyc < 0) a_done_cyc = cyc;
        a_done_n++;
        if (a_valid || a_busy) done_flag_err++;
      end
      if (b_done) begin
        if (b_done_cyc < 0) b_done_cyc = cyc;
        b_done_n++;
        if (b_valid || b_busy) done_flag_err++;
      end
      if (a_valid && out_ready) begin
        qa.push_back(a_data);
        if (a_first < 0) a_first = cyc;
        a_last = cyc;
      end
      if (b_valid && out_ready) begin
        qb.push_back(b_data);
        b_last = cyc;
      end
      prev_stall_a = a_valid && !out_ready; prev_a = a_data;
      prev_stall_b = b_valid && !out_ready; prev_b = b_data;
      @(negedge clk);
      cyc++;
      wr_en = 1'b0; clear = 1'b0; commit = 1'b0;
      reset = 1'b0;
    end
    out_ready = 1'b0;
  endtask

  task automatic check_full(input string tag, input int mode);
    int bad_a, bad_b;
    logic [7:0] e;
    bad_a = 0; bad_b = 0;
    for (int i = 0; i < qa.size() && i < 514; i++) begin
      e = (i < 512) ? exp_q[i] : ((i == 512) ? exp_crc[15:8] : exp_crc[7:0]);
      if (qa[i] !== e) bad_a++;
    end
    for (int i = 0; i < qb.size() && i < 512; i++) if (qb[i] !== exp_q[i]) bad_b++;
    check({tag, "_a_count"}, qa.size(), 514);
    check({tag, "_a_bytes"}, bad_a, 0);
    check({tag, "_b_count"}, qb.size(), 512);
    check({tag, "_b_bytes"}, bad_b, 0);
    check({tag, "_a_done_cyc"}, a_done_cyc, a_last + 1);
    check({tag, "_b_done_cyc"}, b_done_cyc, b_last + 1);
    check({tag, "_done_counts"}, {a_done_n[15:0], b_done_n[15:0]}, 32'h0001_0001);
    check({tag, "_done_flags"}, done_flag_err, 0);
    check({tag, "_stall_stable"}, stall_err, 0);
    check({tag, "_done_single"}, {30'd0, a_done, a_busy}, 0);
    if (mode == 1) check({tag, "_back_to_back"}, a_last - a_first, 513);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = 8'd0; wr_data = 16'd0;
    clear = 1'b0; commit = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 256; i++) tb_mem[i] = 16'h0000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_a_outs", {a_busy, a_valid, a_done, a_data}, 11'h000);
    check("reset_b_outs", {b_busy, b_valid, b_done, b_data}, 11'h000);

    // Empty block: all zero bytes and a zero CRC.
    do_commit(0, 8'd0, 16'd0);
    run_stream(1, -1, -1);
    check_full("zero", 1);
    check("zero_crc", {qa[512], qa[513]}, 16'h0000);

    // All-ones block carries the well-known 0x7FA1 CRC.
    for (int i = 0; i < 256; i++) wr_word(i[7:0], 16'hFFFF);
    do_commit(0, 8'd0, 16'd0);
    run_stream(1, -1, -1);
    check_full("ones", 1);
    check("ones_crc", {qa[512], qa[513]}, 16'h7FA1);

    do_commit(0, 8'd0, 16'd0);
    run_stream(2, -1, -1);
    check_full("ones_rand", 2);
    check("ones_rand_crc", {qa[512], qa[513]}, 16'h7FA1);

    wr_word(8'd0, 16'h1234);
    wr_word(8'd255, 16'hABCD);
    do_commit(0, 8'd0, 16'd0);
    run_stream(1, -1, -1);
    check_full("ends", 1);
    check("ends_beats", {qa[0], qa[1], qa[510], qa[511]}, 32'h1234_ABCD);

    do_commit(1, 8'd0, 16'h5678);
    run_stream(1, -1, -1);
    check_full("commit_wr", 1);
    check("commit_wr_beats", {qa[0], qa[1]}, 16'h5678);

    // Writes, clear and commit during a send must be ignored.
    do_commit(0, 8'd0, 16'd0);
    run_stream(2, 20, -1);
    check_full("busy_ignore", 2);
    check("busy_ignore_w3", {qa[6], qa[7]}, 16'hFFFF);
    do_commit(0, 8'd0, 16'd0);
    run_stream(1, -1, -1);
    check_full("recommit", 1);

    clear = 1'b1; wr_en = 1'b1; wr_addr = 8'd5; wr_data = 16'h1111;
    @(negedge clk);
    clear = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 256; i++) tb_mem[i] = 16'h0000;
    tb_mem[5] = 16'h1111;
    do_commit(0, 8'd0, 16'd0);
    run_stream(1, -1, -1);
    check_full("clear_wr", 1);
    check("clear_wr_beats", {qa[0], qa[10], qa[11]}, 24'h001111);

    // Reset mid-send at beat 100.
    for (int i = 0; i < 256; i++) wr_word(i[7:0], 16'hC3C3);
    do_commit(0, 8'd0, 16'd0);
    run_stream(1, -1, 100);
    check("midreset_beats", qa.size(), 100);
    check("midreset_a_outs", {a_busy, a_valid, a_done, a_data}, 11'h000);
    check("midreset_b_outs", {b_busy, b_valid, b_done, b_data}, 11'h000);
    check("midreset_no_done", a_done_n + b_done_n, 0);
    for (int i = 0; i < 256; i++) tb_mem[i] = 16'h0000;
    do_commit(0, 8'd0, 16'd0);
    run_stream(1, -1, -1);
    check_full("after_reset", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
